head_group_sequencer: RTL and testbench
=======================================

Name: head_group_sequencer

Overview:
- Top-level sequencer for the HLS run_head_group engine.
- Walks every (layer, group) pair in order and drives the engine's ap_ctrl_hs handshake.
- Re-invokes the engine on the same pair until ap_return=1, asserting reset_resources only on the first call of each pair.
- Sits between the host control register block and run_head_group. Provides run-level start, done, abort and timeout-error status.

Parameters:
- NUM_LAYERS, 4, number of layers to sequence (>=1)
- NUM_GROUPS, 2, head groups per layer (>=1)
- MAX_CALLS, 1024, call limit per (layer, group) before error (>=1)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- run_start  in  1  pulse; starts a full run when idle or in error
- run_abort  in  1  pulse; requests stop at the next call boundary
- run_busy  out  1  high from run accept until DONE, ABORT or ERROR exit
- run_done  out  1  one-cycle pulse on normal completion
- run_aborted  out  1  one-cycle pulse when abort is taken
- run_error  out  1  sticky call-limit error
- err_layer  out  32  layer index at the error
- err_group  out  32  group index at the error
- total_calls  out  32  engine calls this run; saturates at 0xFFFFFFFF
- hg_ap_start  out  1  engine ap_start
- hg_ap_ready  in  1  engine ap_ready
- hg_ap_done  in  1  engine ap_done
- hg_ap_return  in  1  engine ap_return (1 = group finished)
- hg_layer_idx  out  32  engine layer_idx
- hg_group_idx  out  32  engine group_idx
- hg_reset_resources  out  1  engine reset_resources

Behaviour:
- Reset: one clock (ap_clk); ap_rst is synchronous and active-high.
  - Every output is 0 after the reset edge, including err_* and total_calls.
  - FSM goes to IDLE; pending abort is cleared.
  - A reset mid-call abandons the call; the engine shares ap_rst.
- All outputs are registered.
- States: IDLE, CALL, WAIT_DONE, EVAL, GAP, DONE, ERROR.
- IDLE:
  - run_start=1 -> layer=0, group=0, call_cnt=0, first=1, total_calls=0; clear run_error, err_*; go to CALL.
  - run_busy=1 from the next cycle.
- CALL:
  - hg_ap_start=1; hg_reset_resources=first.
  - hg_layer_idx and hg_group_idx hold the current pair; they are stable through CALL, WAIT_DONE and EVAL.
  - On hg_ap_ready=1: hg_ap_start drops the next cycle.
    - If hg_ap_done=1 in the same cycle: latch hg_ap_return, go to EVAL.
    - Otherwise go to WAIT_DONE.
  - hg_ap_start is never withdrawn before hg_ap_ready, even when abort is pending.
- WAIT_DONE:
  - hg_ap_start=0.
  - On hg_ap_done=1: latch hg_ap_return, go to EVAL.
- EVAL (one cycle):
  - call_cnt++; total_calls++ (saturating); first=0.
  - Priority order:
    1. Abort pending -> pulse run_aborted, go to IDLE. No run_done.
    2. ret=1 and layer=NUM_LAYERS-1 and group=NUM_GROUPS-1 -> DONE.
    3. ret=1 -> advance the pair, call_cnt=0, first=1, go to GAP.
       - group=NUM_GROUPS-1 wraps group to 0 and increments layer.
       - Otherwise group increments.
    4. ret=0 and call_cnt+1 >= MAX_CALLS -> latch err_layer/err_group, set run_error, go to ERROR.
    5. Otherwise -> GAP.
- GAP: one cycle with hg_ap_start=0, then CALL. There is always at least one low cycle of hg_ap_start between calls.
- DONE: run_done=1 for one cycle, run_busy=0, then IDLE.
- ERROR:
  - run_busy=0, hg_ap_start=0; run_error and err_* hold.
  - run_start clears the error and begins a new run, as from IDLE.
- run_abort:
  - Sampled in CALL, WAIT_DONE, EVAL and GAP; sets abort pending, taken at the next EVAL.
  - Abort in GAP: the pending flag blocks the next CALL; go to IDLE with a run_aborted pulse.
  - Ignored in IDLE, DONE and ERROR.
- run_start while run_busy=1 is ignored.
- Simultaneous run_start and run_abort in IDLE: start wins, abort is ignored.
- Index arithmetic: 32-bit unsigned; indices never exceed NUM_*-1.

Test Plan:
1. Basic walk.
   - Stimulus: NUM_LAYERS=2, NUM_GROUPS=2; stub asserts ap_ready and ap_done 3 cycles after start, always returns 1.
   - Required: pairs (0,0),(0,1),(1,0),(1,1); hg_reset_resources=1 on every call; a single run_done pulse; total_calls=4; run_busy low afterwards.
2. Repeated calls per group.
   - Stimulus: stub returns 0,0,1 per pair.
   - Required: 3 calls per pair; hg_reset_resources=1 only on the first call of each pair; total_calls=12; hg_ap_start low for at least 1 cycle between calls.
3. Zero-latency engine.
   - Stimulus: stub asserts ap_ready and ap_done in the first start cycle.
   - Required: hg_ap_start high for exactly 1 cycle per call; indices stable during that cycle.
4. Call-limit error.
   - Stimulus: MAX_CALLS=8; stub returns 0 forever at pair (1,0).
   - Required after the 8th call: run_error=1, err_layer=1, err_group=0, hg_ap_start stays 0.
   - Then run_start: run_error clears and the run restarts at (0,0).
5. Abort.
   - Stimulus: run_abort pulsed during WAIT_DONE of pair (0,1).
   - Required: the call completes; run_aborted pulses in EVAL; no further hg_ap_start; run_done stays 0; FSM returns to IDLE.
6. Reset and busy start.
   - Stimulus: ap_rst during WAIT_DONE; separately, run_start while busy.
   - Required: all outputs are 0 the cycle after reset. A run_start while busy leaves the sequence, indices and total_calls unaffected.

Source files
------------

// File: rtl/head_group_sequencer.sv
// Run-level sequencer for run_head_group: walks every (layer, group) pair and drives
// the engine's ap_ctrl_hs handshake, re-calling a pair until the engine returns 1.
module head_group_sequencer #(
   parameter int NUM_LAYERS = 4,
   parameter int NUM_GROUPS = 2,
   parameter int MAX_CALLS  = 1024
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        run_start,
   input  logic        run_abort,
   output logic        run_busy,
   output logic        run_done,
   output logic        run_aborted,
   output logic        run_error,
   output logic [31:0] err_layer,
   output logic [31:0] err_group,
   output logic [31:0] total_calls,
   output logic        hg_ap_start,
   input  logic        hg_ap_ready,
   input  logic        hg_ap_done,
   input  logic        hg_ap_return,
   output logic [31:0] hg_layer_idx,
   output logic [31:0] hg_group_idx,
   output logic        hg_reset_resources,
   output logic [2:0]  dbg_state
);

   // Engine handshake (ap_ctrl_hs): ap_start rises to request a call and is held
   // until ap_ready is seen high at a clock edge; ap_done (possibly in the same
   // cycle as ap_ready) marks the call result, with ap_return valid alongside it.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CALL      = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_EVAL      = 3'd3,
      S_GAP       = 3'd4,
      S_DONE      = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   localparam logic [31:0] LAST_LAYER = 32'(NUM_LAYERS - 1);
   localparam logic [31:0] LAST_GROUP = 32'(NUM_GROUPS - 1);
   localparam logic [31:0] CALL_LIMIT = 32'(MAX_CALLS);

   state_t      state_q;
   logic [31:0] layer_q;
   logic [31:0] group_q;
   logic [31:0] call_cnt_q;
   logic [31:0] total_q;
   logic [31:0] err_layer_q;
   logic [31:0] err_group_q;
   logic        first_q;
   logic        abort_q;
   logic        ret_q;
   logic        busy_q;
   logic        done_q;
   logic        aborted_q;
   logic        error_q;
   logic        start_q;
   logic        reset_res_q;

   logic [31:0] call_cnt_d;
   logic [31:0] total_d;
   logic        last_pair;

   assign call_cnt_d = call_cnt_q + 32'd1;
   assign total_d    = (total_q == 32'hFFFF_FFFF) ? total_q : total_q + 32'd1;
   assign last_pair  = (layer_q == LAST_LAYER) && (group_q == LAST_GROUP);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= S_IDLE;
         layer_q     <= '0;
         group_q     <= '0;
         call_cnt_q  <= '0;
         total_q     <= '0;
         err_layer_q <= '0;
         err_group_q <= '0;
         first_q     <= 1'b0;
         abort_q     <= 1'b0;
         ret_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         error_q     <= 1'b0;
         start_q     <= 1'b0;
         reset_res_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (run_start) begin
                  layer_q     <= '0;
                  group_q     <= '0;
                  call_cnt_q  <= '0;
                  total_q     <= '0;
                  err_layer_q <= '0;
                  err_group_q <= '0;
                  error_q     <= 1'b0;
                  first_q     <= 1'b1;
                  abort_q     <= 1'b0;
                  busy_q      <= 1'b1;
                  start_q     <= 1'b1;
                  reset_res_q <= 1'b1;
                  state_q     <= S_CALL;
               end
            end
            S_CALL: begin
               if (run_abort) abort_q <= 1'b1;
               // ap_start is held until ready regardless of a pending abort.
               if (hg_ap_ready) begin
                  start_q     <= 1'b0;
                  reset_res_q <= 1'b0;
                  if (hg_ap_done) begin
                     ret_q   <= hg_ap_return;
                     state_q <= S_EVAL;
                  end else begin
                     state_q <= S_WAIT_DONE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (run_abort) abort_q <= 1'b1;
               if (hg_ap_done) begin
                  ret_q   <= hg_ap_return;
                  state_q <= S_EVAL;
               end
            end
            S_EVAL: begin
               call_cnt_q <= call_cnt_d;
               total_q    <= total_d;
               first_q    <= 1'b0;
               if (abort_q) begin
                  aborted_q <= 1'b1;
                  abort_q   <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (ret_q && last_pair) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else if (ret_q) begin
                  if (group_q == LAST_GROUP) begin
                     group_q <= '0;
                     layer_q <= layer_q + 32'd1;
                  end else begin
                     group_q <= group_q + 32'd1;
                  end
                  call_cnt_q <= '0;
                  first_q    <= 1'b1;
                  if (run_abort) abort_q <= 1'b1;
                  state_q    <= S_GAP;
               end else if (call_cnt_d >= CALL_LIMIT) begin
                  err_layer_q <= layer_q;
                  err_group_q <= group_q;
                  error_q     <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_ERROR;
               end else begin
                  if (run_abort) abort_q <= 1'b1;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               // A pending or fresh abort stops the walk before the next call.
               if (abort_q || run_abort) begin
                  aborted_q <= 1'b1;
                  abort_q   <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  start_q     <= 1'b1;
                  reset_res_q <= first_q;
                  state_q     <= S_CALL;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign run_busy           = busy_q;
   assign run_done           = done_q;
   assign run_aborted        = aborted_q;
   assign run_error          = error_q;
   assign err_layer          = err_layer_q;
   assign err_group          = err_group_q;
   assign total_calls        = total_q;
   assign hg_ap_start        = start_q;
   assign hg_layer_idx       = layer_q;
   assign hg_group_idx       = group_q;
   assign hg_reset_resources = reset_res_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_head_group_sequencer.sv
// Bench for head_group_sequencer: table of whole-run scenarios against a stub engine,
// plus hand-written abort, reset-mid-call and power-on sequences.
module tb_head_group_sequencer;

   localparam int NL = 2;
   localparam int NG = 2;
   localparam int MC = 8;
   localparam int W  = 25;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        run_start;
   logic        run_abort;
   logic        run_busy;
   logic        run_done;
   logic        run_aborted;
   logic        run_error;
   logic [31:0] err_layer;
   logic [31:0] err_group;
   logic [31:0] total_calls;
   logic        hg_ap_start;
   logic        hg_ap_ready;
   logic        hg_ap_done;
   logic        hg_ap_return;
   logic [31:0] hg_layer_idx;
   logic [31:0] hg_group_idx;
   logic        hg_reset_resources;
   logic [2:0]  dbg_state;

   head_group_sequencer #(.NUM_LAYERS(NL), .NUM_GROUPS(NG), .MAX_CALLS(MC)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .run_start(run_start), .run_abort(run_abort),
      .run_busy(run_busy), .run_done(run_done), .run_aborted(run_aborted),
      .run_error(run_error), .err_layer(err_layer), .err_group(err_group),
      .total_calls(total_calls),
      .hg_ap_start(hg_ap_start), .hg_ap_ready(hg_ap_ready), .hg_ap_done(hg_ap_done),
      .hg_ap_return(hg_ap_return), .hg_layer_idx(hg_layer_idx),
      .hg_group_idx(hg_group_idx), .hg_reset_resources(hg_reset_resources),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 ap_clk = ~ap_clk;

   // ---------------- stub engine ----------------
   // ready (and done when lag=0) after stub_lat extra start cycles; otherwise done
   // follows ready by stub_lag cycles. Mode 0: return 1; mode 1: 0,0,1 per pair;
   // mode 2: return 0 forever at pair (1,0).
   int         stub_lat = 0;
   int         stub_lag = 0;
   int         stub_mode = 0;
   logic       stub_clr = 1'b0;
   logic [7:0] st_cnt;
   logic       st_wait;
   logic [7:0] st_wcnt;
   logic [7:0] st_pcalls;
   logic       hs;
   logic       ret_now;

   assign hs           = hg_ap_start && (st_cnt == 8'(stub_lat));
   assign hg_ap_ready  = hs;
   assign hg_ap_done   = (hs && stub_lag == 0) || (st_wait && st_wcnt == 8'd1);
   assign hg_ap_return = ret_now;

   always_comb begin
      ret_now = 1'b1;
      if (stub_mode == 1) ret_now = (st_pcalls == 8'd2);
      else if (stub_mode == 2) ret_now = !(hg_layer_idx == 32'd1 && hg_group_idx == 32'd0);
   end

   always @(posedge ap_clk) begin
      if (ap_rst || stub_clr) begin
         st_cnt    <= '0;
         st_wait   <= 1'b0;
         st_wcnt   <= '0;
         st_pcalls <= '0;
      end else begin
         if (hs) st_cnt <= '0;
         else if (hg_ap_start) st_cnt <= st_cnt + 8'd1;
         if (hs && stub_lag != 0) begin
            st_wait <= 1'b1;
            st_wcnt <= 8'(stub_lag);
         end else if (st_wait) begin
            if (st_wcnt == 8'd1) st_wait <= 1'b0;
            else st_wcnt <= st_wcnt - 8'd1;
         end
         if (hg_ap_done) st_pcalls <= ret_now ? 8'd0 : st_pcalls + 8'd1;
      end
   end

   // ---------------- monitor ----------------
   logic [W-1:0] act_q[$];
   logic [W-1:0] exp_q[$];
   int          start_len, gap_err, stab_err, done_cnt, abort_cnt;
   logic        prev_start, prev_hs, prev_rst;
   logic [31:0] prev_l, prev_g;
   logic        mon_clr = 1'b0;

   always @(negedge ap_clk) begin
      if (mon_clr) begin
         act_q.delete();
         start_len = 0; gap_err = 0; stab_err = 0; done_cnt = 0; abort_cnt = 0;
         prev_start = 1'b0; prev_hs = 1'b0; prev_rst = 1'b0; prev_l = '0; prev_g = '0;
      end else begin
         if (hg_ap_start) begin
            if (prev_start && !prev_hs && (hg_layer_idx != prev_l || hg_group_idx != prev_g ||
                hg_reset_resources != prev_rst))
               stab_err = stab_err + 1;
            start_len = start_len + 1;
         end
         if (prev_hs && hg_ap_start) gap_err = gap_err + 1;
         if (hg_ap_start && hg_ap_ready) begin
            act_q.push_back({hg_layer_idx[7:0], hg_group_idx[7:0], hg_reset_resources,
                             8'(start_len)});
            start_len = 0;
         end
         if (run_done) done_cnt = done_cnt + 1;
         if (run_aborted) abort_cnt = abort_cnt + 1;
         prev_start = hg_ap_start;
         prev_hs    = hg_ap_start && hg_ap_ready;
         prev_rst   = hg_reset_resources;
         prev_l     = hg_layer_idx;
         prev_g     = hg_group_idx;
      end
   end

   // ---------------- scoreboard helpers ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected call log for a full run, built from the walk rules.
   task automatic build_exp(input int lat, input int mode);
      exp_q.delete();
      for (int l = 0; l < NL; l++) begin
         for (int g = 0; g < NG; g++) begin
            int n;
            n = (mode == 1) ? 3 : ((mode == 2 && l == 1 && g == 0) ? MC : 1);
            for (int c = 0; c < n; c++)
               exp_q.push_back({8'(l), 8'(g), (c == 0), 8'(lat + 1)});
            if (mode == 2 && l == 1 && g == 0) return;
         end
      end
   endtask

   task automatic prep(input int lat, input int lag, input int mode);
      stub_lat = lat; stub_lag = lag; stub_mode = mode;
      stub_clr = 1'b1; mon_clr = 1'b1;
      @(negedge ap_clk); #1;
      stub_clr = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic wait_hs(input logic [31:0] l, input logic [31:0] g, input string name);
      int cyc;
      cyc = 0;
      while (!(hg_ap_start && hg_ap_ready && hg_layer_idx == l && hg_group_idx == g) &&
             cyc < 300) begin
         @(negedge ap_clk); cyc++;
      end
      chk(name, 32'(cyc < 300), 32'd1);
   endtask

   typedef struct {
      int lat; int lag; int mode; int busy_start_at;
      int exp_total; int exp_done; int exp_err; int exp_el; int exp_eg;
   } row_t;
   row_t rows[5];

   task automatic run_row(input int r);
      int cyc;
      prep(rows[r].lat, rows[r].lag, rows[r].mode);
      build_exp(rows[r].lat, rows[r].mode);
      run_start = 1'b1;
      @(negedge ap_clk);
      run_start = 1'b0;
      chk($sformatf("r%0d busy_rise", r), 32'(run_busy), 32'd1);
      chk($sformatf("r%0d err_clr", r), 32'(run_error), 32'd0);
      chk($sformatf("r%0d total_clr", r), total_calls, 32'd0);
      cyc = 0;
      while (run_busy && cyc < 3000) begin
         @(negedge ap_clk); cyc++;
         run_start = (cyc == rows[r].busy_start_at);
      end
      run_start = 1'b0;
      chk($sformatf("r%0d timeout", r), 32'(cyc < 3000), 32'd1);
      repeat (4) @(negedge ap_clk);
      #1;
      chk($sformatf("r%0d ncalls", r), 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         chk($sformatf("r%0d call%0d", r, i), 32'(act_q[i]), 32'(exp_q[i]));
      chk($sformatf("r%0d total", r), total_calls, 32'(rows[r].exp_total));
      chk($sformatf("r%0d done_pulses", r), 32'(done_cnt), 32'(rows[r].exp_done));
      chk($sformatf("r%0d abort_pulses", r), 32'(abort_cnt), 32'd0);
      chk($sformatf("r%0d error", r), 32'(run_error), 32'(rows[r].exp_err));
      chk($sformatf("r%0d err_layer", r), err_layer, 32'(rows[r].exp_el));
      chk($sformatf("r%0d err_group", r), err_group, 32'(rows[r].exp_eg));
      chk($sformatf("r%0d busy_low", r), 32'(run_busy), 32'd0);
      chk($sformatf("r%0d start_low", r), 32'(hg_ap_start), 32'd0);
      chk($sformatf("r%0d gap", r), 32'(gap_err), 32'd0);
      chk($sformatf("r%0d idx_stable", r), 32'(stab_err), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, 32'(run_busy), 32'd0);
      chk({tag, " done"}, 32'(run_done), 32'd0);
      chk({tag, " aborted"}, 32'(run_aborted), 32'd0);
      chk({tag, " error"}, 32'(run_error), 32'd0);
      chk({tag, " err_layer"}, err_layer, 32'd0);
      chk({tag, " err_group"}, err_group, 32'd0);
      chk({tag, " total"}, total_calls, 32'd0);
      chk({tag, " start"}, 32'(hg_ap_start), 32'd0);
      chk({tag, " layer"}, hg_layer_idx, 32'd0);
      chk({tag, " group"}, hg_group_idx, 32'd0);
      chk({tag, " reset_res"}, 32'(hg_reset_resources), 32'd0);
      chk({tag, " state"}, 32'(dbg_state), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      //          lat lag mode bs total done err el eg
      rows[0] = '{3, 0, 0, 0, 4,  1, 0, 0, 0};   // basic walk
      rows[1] = '{1, 0, 1, 7, 12, 1, 0, 0, 0};   // 0,0,1 per pair, start while busy
      rows[2] = '{0, 0, 0, 0, 4,  1, 0, 0, 0};   // zero-latency engine
      rows[3] = '{2, 0, 2, 0, 10, 0, 1, 1, 0};   // call limit at (1,0)
      rows[4] = '{1, 2, 0, 0, 4,  1, 0, 0, 0};   // restart from error, done after ready

      ap_rst = 1'b1; run_start = 1'b0; run_abort = 1'b0;
      prep(0, 0, 0);
      repeat (3) @(negedge ap_clk);
      ap_rst = 1'b0;
      chk_all_zero("por");

      for (int r = 0; r < 5; r++) run_row(r);

      // Abort during WAIT_DONE of pair (0,1).
      prep(0, 4, 0);
      run_start = 1'b1;
      @(negedge ap_clk);
      run_start = 1'b0;
      wait_hs(32'd0, 32'd1, "abort hs01");
      @(negedge ap_clk);
      chk("abort in_wait", 32'(dbg_state), 32'd2);
      run_abort = 1'b1;
      @(negedge ap_clk);
      run_abort = 1'b0;
      repeat (20) @(negedge ap_clk);
      #1;
      chk("abort ncalls", 32'(act_q.size()), 32'd2);
      chk("abort pulses", 32'(abort_cnt), 32'd1);
      chk("abort done_pulses", 32'(done_cnt), 32'd0);
      chk("abort total", total_calls, 32'd2);
      chk("abort busy", 32'(run_busy), 32'd0);
      chk("abort start", 32'(hg_ap_start), 32'd0);
      chk("abort idle", 32'(dbg_state), 32'd0);

      // Reset while waiting for done of pair (1,0).
      prep(0, 5, 0);
      run_start = 1'b1;
      @(negedge ap_clk);
      run_start = 1'b0;
      wait_hs(32'd1, 32'd0, "rst hs10");
      @(negedge ap_clk);
      chk("rst pre_total", total_calls, 32'd2);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      chk_all_zero("midrst");

      run_row(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
